// File: rtl/tcmp_pkg.sv
// Shared definitions for the two's-complement negation sequencer.
package tcmp_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/tcmp_serial_neg_bit.sv
// Bit-serial two's-complement negation cell, LSB first.
// Bits up to and including the first 1 pass through; later bits invert.
module serial_neg_bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic a,
    output logic s
);

    logic z;

    // z remembers whether a 1 has been seen in the current word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s <= 1'b0;
            z <= 1'b0;
        end else begin
            s <= a ^ z;
            z <= a | z;
        end
    end

endmodule

// File: rtl/tcmp_seq.sv
// Word-level sequencer: parallel in, bit-serial negation, parallel out.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | feeding operand bits to the cell and collecting result bits
// DONE  | result presented, waiting for out_ready
module tcmp_seq
    import tcmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             msb_in;
    logic             accept;
    logic             cell_a;
    logic             cell_s;

    assign accept = in_valid && in_ready;

    // The cell is cleared on the accepting edge so bit 0 sees z=0.
    serial_neg_bit u_cell (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .a   (cell_a),
        .s   (cell_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only (no in->out comb paths).
    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        cell_a    = (state == ST_SHIFT) ? opnd[0] : 1'b0;
        out_data  = res;
        out_ovf   = (state == ST_DONE) && msb_in && res[WIDTH-1];
    end

    // Operand/result shift registers and bit counter. The cell output lags
    // by one cycle, so result bits are captured while cnt is 1..WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd   <= '0;
            res    <= '0;
            cnt    <= '0;
            msb_in <= 1'b0;
        end else if (accept) begin
            opnd   <= in_data;
            msb_in <= in_data[WIDTH-1];
            cnt    <= '0;
        end else if (state == ST_SHIFT) begin
            opnd <= opnd >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (cnt != '0) begin
                res <= {cell_s, res[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_tcmp_seq.sv
// Bench for tcmp_seq: scoreboard on an 8-bit instance plus a 16-bit spot test.
module tb_tcmp_seq;

    localparam int W   = 8;
    localparam int W16 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, out_ovf, busy;
    logic [W-1:0]  out_data;

    logic          in_valid16 = 1'b0;
    logic          out_ready16 = 1'b1;
    logic [W16-1:0] in_data16 = '0;
    logic          in_ready16, out_valid16, out_ovf16, busy16;
    logic [W16-1:0] out_data16;

    tcmp_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
    );

    tcmp_seq #(.WIDTH(W16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_data(out_data16), .out_ovf(out_ovf16), .busy(busy16)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];

    // Reference: arithmetic negation mod 2^W; overflow only for the most-negative value.
    function automatic exp_t model(input logic [W-1:0] x, input int acc);
        exp_t e;
        int v;
        v = int'(x);
        e.data = W'((1 << W) - v);
        e.ovf  = (v == (1 << (W - 1)));
        e.acc  = acc;
        return e;
    endfunction

    bit chk_spacing = 1'b0;
    int last_acc = -1;

    // Input side: predicts the result of every accepted word.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(model(in_data, cyc + 1));
            if (chk_spacing && last_acc >= 0)
                chk("accept_spacing", 64'(cyc + 1 - last_acc), 64'(W + 3));
            last_acc = cyc + 1;
        end
    end

    bit           pv = 1'b0;
    bit           pr = 1'b0;
    logic [W-1:0] hd;
    logic         ho;

    // Output side: compares presented results against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            chk("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
            if (pv && pr)
                chk("out_valid_after_handoff", 64'(out_valid), 64'(0));
            else if (out_valid && !pv) begin
                chk("unexpected_output", 64'(sb.size()), 64'(1) <= 64'(sb.size()) ? 64'(sb.size()) : 64'(1));
                if (sb.size() > 0) begin
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    chk("out_ovf", 64'(out_ovf), 64'(sb[0].ovf));
                    chk("latency", 64'(cyc - sb[0].acc), 64'(W + 1));
                end
            end else if (out_valid && pv && !pr) begin
                chk("hold_data", 64'(out_data), 64'(hd));
                chk("hold_ovf", 64'(out_ovf), 64'(ho));
            end
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            pv = out_valid;
            pr = out_ready;
            hd = out_data;
            ho = out_ovf;
        end
    end

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !out_valid && !busy) break;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    bit rand_ready = 1'b0;

    initial begin
        logic [W-1:0]   dir [4];
        logic [W16-1:0] d16 [2];
        logic [W16-1:0] e16;
        int             acc16;
        int             k;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Directed words.
        dir[0] = 8'h05; dir[1] = 8'h00; dir[2] = 8'h80; dir[3] = 8'h7F;
        for (int i = 0; i < 4; i++) begin
            send(dir[i]);
            in_valid = 1'b0;
            drain();
        end

        // Back-pressure with ignored in_valid pulses.
        out_ready = 1'b0;
        send(8'h01);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_out_valid_rise", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            in_data  = W'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_data", 64'(out_data), 64'(8'hFF));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_after_handoff", 64'(in_ready), 64'(1));
        send(8'hFF);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a word (cnt=4).
        send(8'h10);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rm_busy", 64'(busy), 64'(0));
        chk("rm_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rm_no_valid", 64'(out_valid), 64'(0));
        end
        send(8'h03);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream with in_valid held high.
        chk_spacing = 1'b1;
        last_acc = -1;
        send(8'h01);
        send(8'h02);
        send(8'h80);
        send(8'hFE);
        in_valid = 1'b0;
        drain();
        chk_spacing = 1'b0;

        // Random words with random back-pressure.
        rand_ready = 1'b1;
        fork
            while (rand_ready) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(W'($urandom));
            in_valid = 1'b0;
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // 16-bit instance.
        d16[0] = 16'h7FFF; d16[1] = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            in_valid16 = 1'b1;
            in_data16  = d16[i];
            @(negedge clk);
            chk("w16_in_ready", 64'(in_ready16), 64'(1));
            acc16 = cyc + 1;
            @(posedge clk);
            #1 in_valid16 = 1'b0;
            k = 0;
            while (!out_valid16 && k < 60) begin
                @(negedge clk);
                k++;
            end
            e16 = W16'((1 << W16) - int'(d16[i]));
            chk("w16_valid", 64'(out_valid16), 64'(1));
            chk("w16_latency", 64'(cyc - acc16), 64'(W16 + 1));
            chk("w16_data", 64'(out_data16), 64'(e16));
            chk("w16_ovf", 64'(out_ovf16), 64'(d16[i] == 16'h8000));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
